// File: rtl/fifo_stream_drain.sv
// Read-side drain engine: pops a synchronous FIFO into a 2-entry buffer and
// presents it as a valid/ready stream with fixed-length packet framing.
module fifo_stream_drain #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PKT_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_error_i,
  output logic             fifo_rd_en_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_last_o,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic             err_o,
  input  logic             clr_err_i
);

  logic [1:0]       buf_cnt, buf_cnt_d;
  logic             pend;
  logic [WIDTH-1:0] buf0, buf1, buf0_d, buf1_d;
  logic [CNT_W-1:0] beat_cnt;
  logic             hs;
  logic             is_last;
  logic [2:0]       occ;

  assign m_valid_o = (buf_cnt != 2'd0);
  assign m_data_o  = buf0;
  assign hs        = m_valid_o & m_ready_i;
  assign is_last   = (beat_cnt == CNT_W'(PKT_LEN - 1));
  assign m_last_o  = m_valid_o & is_last;

  // Occupancy after this cycle's handshake; hs implies buf_cnt >= 1, so no underflow.
  assign occ = {1'b0, buf_cnt} + {2'b00, pend} - {2'b00, hs};
  assign fifo_rd_en_o = rst_ni & enable_i & ~fifo_empty_i & (occ < 3'd2);

  always_comb begin
    buf0_d    = buf0;
    buf1_d    = buf1;
    buf_cnt_d = buf_cnt;
    case ({hs, pend})
      2'b11: begin
        // Pop head and append in one edge; with one entry the new word becomes head.
        if (buf_cnt == 2'd2) begin
          buf0_d = buf1;
          buf1_d = fifo_rdata_i;
        end else begin
          buf0_d = fifo_rdata_i;
        end
      end
      2'b10: begin
        buf0_d    = buf1;
        buf_cnt_d = buf_cnt - 2'd1;
      end
      2'b01: begin
        if (buf_cnt == 2'd0) buf0_d = fifo_rdata_i;
        else                 buf1_d = fifo_rdata_i;
        buf_cnt_d = buf_cnt + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_cnt <= '0;
      pend    <= 1'b0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      buf_cnt <= buf_cnt_d;
      pend    <= fifo_rd_en_o;
      buf0    <= buf0_d;
      buf1    <= buf1_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt  <= '0;
      pkt_cnt_o <= '0;
    end else if (hs) begin
      if (is_last) begin
        beat_cnt  <= '0;
        pkt_cnt_o <= pkt_cnt_o + 1'b1;
      end else begin
        beat_cnt  <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           err_o <= 1'b0;
    else if (fifo_error_i) err_o <= 1'b1;
    else if (clr_err_i)    err_o <= 1'b0;
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain with a behavioural FIFO and a data scoreboard.
module tb_fifo_stream_drain;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned PKT_LEN = 4;
  localparam int unsigned CNT_W   = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             enable_i;
  logic             fifo_empty_i;
  logic [WIDTH-1:0] fifo_rdata_i = '0;
  logic             fifo_error_i;
  logic             fifo_rd_en_o;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [WIDTH-1:0] m_data_o;
  logic             m_last_o;
  logic [CNT_W-1:0] pkt_cnt_o;
  logic             err_o;
  logic             clr_err_i;

  always #5 clk_i = ~clk_i;

  fifo_stream_drain #(
    .WIDTH  (WIDTH),
    .PKT_LEN(PKT_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .enable_i    (enable_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_rdata_i(fifo_rdata_i),
    .fifo_error_i(fifo_error_i),
    .fifo_rd_en_o(fifo_rd_en_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .pkt_cnt_o   (pkt_cnt_o),
    .err_o       (err_o),
    .clr_err_i   (clr_err_i)
  );

  // Behavioural FIFO: registered read data, combinational empty.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = '0;
  logic [7:0] rd_ptr = '0;
  int         pops   = 0;

  assign fifo_empty_i = (wr_ptr == rd_ptr);

  always @(posedge clk_i) begin
    if (fifo_rd_en_o) begin
      fifo_rdata_i <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 8'd1;
      pops         <= pops + 1;
    end
  end

  int               n_assert = 0;
  int               n_fail   = 0;
  logic [7:0]       exp_q [$];
  int unsigned      exp_beat = 0;
  logic [CNT_W-1:0] exp_pkt  = '0;
  int               cyc = 0;
  int               first_pop, first_valid, first_hs, last_hs;
  int               n_hs = 0;
  logic             prev_stall = 1'b0;
  logic [7:0]       prev_data  = '0;
  logic             prev_last  = 1'b0;
  int               p0, n0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
    exp_q.push_back(w);
  endtask

  task automatic mon();
    logic [7:0] e;
    chk("pop_while_empty", 32'(fifo_rd_en_o & fifo_empty_i), 32'd0);
    if (first_pop < 0 && fifo_rd_en_o) first_pop = cyc;
    if (first_valid < 0 && m_valid_o)  first_valid = cyc;
    if (prev_stall) begin
      chk("hold_valid", 32'(m_valid_o), 32'd1);
      chk("hold_data", 32'(m_data_o), 32'(prev_data));
      chk("hold_last", 32'(m_last_o), 32'(prev_last));
    end
    if (m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(m_data_o), 32'(e));
        chk("beat_last", 32'(m_last_o), 32'(exp_beat == PKT_LEN - 1));
        if (exp_beat == PKT_LEN - 1) begin
          exp_beat = 0;
          exp_pkt  = exp_pkt + 1'b1;
        end else begin
          exp_beat++;
        end
      end
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      n_hs++;
    end
    prev_stall = m_valid_o & ~m_ready_i;
    prev_data  = m_data_o;
    prev_last  = m_last_o;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk_i);
    mon();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni       = 1'b0;
    enable_i     = 1'b1;
    m_ready_i    = 1'b1;
    fifo_error_i = 1'b0;
    clr_err_i    = 1'b0;
    first_pop    = -1;
    first_valid  = -1;
    first_hs     = -1;
    last_hs      = -1;

    // Reset state, FIFO already loaded and enable high
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    #3;
    chk("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_data", 32'(m_data_o), 32'd0);
    chk("rst_last", 32'(m_last_o), 32'd0);
    chk("rst_pkt", 32'(pkt_cnt_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    tick();
    tick();
    rst_ni = 1'b1;

    // Full-rate stream of two packets
    drain(40);
    chk("latency", 32'(first_valid - first_pop), 32'd2);
    chk("burst8_gapless", 32'(last_hs - first_hs), 32'd7);
    chk("pkt_after_8", 32'(pkt_cnt_o), 32'(exp_pkt));
    chk("pkt_is_2", 32'(pkt_cnt_o), 32'd2);
    chk("idle_rd_en", 32'(fifo_rd_en_o), 32'd0);
    chk("idle_valid", 32'(m_valid_o), 32'd0);
    chk("fifo_empty", 32'(fifo_empty_i), 32'd1);

    // Backpressure: two pops then stop, head held
    m_ready_i = 1'b0;
    p0 = pops;
    for (int i = 0; i < 6; i++) push(8'h21 + 8'(i));
    repeat (6) tick();
    chk("bp_pops", 32'(pops - p0), 32'd2);
    chk("bp_rd_en", 32'(fifo_rd_en_o), 32'd0);
    chk("bp_valid", 32'(m_valid_o), 32'd1);
    chk("bp_head", 32'(m_data_o), 32'h21);
    m_ready_i = 1'b1;
    first_hs  = -1;
    drain(30);
    chk("bp_release_gapless", 32'(last_hs - first_hs), 32'd5);
    chk("bp_pops_total", 32'(pops - p0), 32'd6);

    // Toggling ready
    p0 = pops;
    for (int i = 0; i < 10; i++) push(8'h31 + 8'(i));
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      m_ready_i = (i % 2 == 0);
      tick();
    end
    chk("toggle_drained", 32'(exp_q.size()), 32'd0);
    chk("toggle_pops", 32'(pops - p0), 32'd10);
    m_ready_i = 1'b1;
    chk("pkt_after_toggle", 32'(pkt_cnt_o), 32'(exp_pkt));

    // enable dropped right after a pop
    enable_i = 1'b0;
    p0 = pops;
    n0 = n_hs;
    for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
    repeat (2) tick();
    chk("dis_no_pop", 32'(pops - p0), 32'd0);
    enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
    repeat (5) tick();
    chk("dis_one_pop", 32'(pops - p0), 32'd1);
    chk("dis_pending_delivered", 32'(n_hs - n0), 32'd1);
    chk("dis_rd_en", 32'(fifo_rd_en_o), 32'd0);
    enable_i = 1'b1;
    drain(30);
    chk("dis_pops_total", 32'(pops - p0), 32'd4);

    // Sticky error
    chk("err_clear_initial", 32'(err_o), 32'd0);
    fifo_error_i = 1'b1;
    tick();
    fifo_error_i = 1'b0;
    chk("err_set", 32'(err_o), 32'd1);
    tick();
    chk("err_sticky", 32'(err_o), 32'd1);
    clr_err_i    = 1'b1;
    fifo_error_i = 1'b1;
    tick();
    fifo_error_i = 1'b0;
    chk("err_set_wins", 32'(err_o), 32'd1);
    tick();
    clr_err_i = 1'b0;
    chk("err_cleared", 32'(err_o), 32'd0);

    // Reset mid-packet with a full buffer
    push(8'h50);
    drain(20);
    fifo_error_i = 1'b1;
    tick();
    fifo_error_i = 1'b0;
    m_ready_i = 1'b0;
    p0 = pops;
    for (int i = 0; i < 6; i++) push(8'h51 + 8'(i));
    repeat (5) tick();
    chk("pre_rst_pops", 32'(pops - p0), 32'd2);
    chk("pre_rst_err", 32'(err_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid_o), 32'd0);
    chk("arst_last", 32'(m_last_o), 32'd0);
    chk("arst_pkt", 32'(pkt_cnt_o), 32'd0);
    chk("arst_err", 32'(err_o), 32'd0);
    chk("arst_rd_en", 32'(fifo_rd_en_o), 32'd0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    exp_beat   = 0;
    exp_pkt    = '0;
    prev_stall = 1'b0;
    tick();
    rst_ni    = 1'b1;
    m_ready_i = 1'b1;
    drain(30);
    chk("post_rst_pkt", 32'(pkt_cnt_o), 32'd1);
    chk("post_rst_valid", 32'(m_valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
